// File: rtl/sync_event_arbiter_pkg.sv
// Shared types and parameter limits for the event arbiter.
package sync_event_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int NREQ_MIN  = 2;
  localparam int NREQ_MAX  = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 8;

  function automatic bit params_legal(input int nreq, input int cnt_w);
    return (nreq >= NREQ_MIN) && (nreq <= NREQ_MAX) &&
           (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting index after last_id, wrapping to 0.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_id,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  logic           any_hit;
  logic           hi_hit;
  logic [IDW-1:0] any_id;
  logic [IDW-1:0] hi_id;

  // Scanning downward lets the lowest matching index overwrite earlier hits.
  always_comb begin
    any_hit = 1'b0;
    hi_hit  = 1'b0;
    any_id  = '0;
    hi_id   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_hit = 1'b1;
        any_id  = IDW'(i);
        if (IDW'(i) > last_id) begin
          hi_hit = 1'b1;
          hi_id  = IDW'(i);
        end
      end
    end
  end

  assign gnt_valid = any_hit;
  assign gnt_id    = hi_hit ? hi_id : any_id;

endmodule

// File: rtl/sync_event_arbiter.sv
// Counts rising edges per channel and hands out coalesced event records round-robin.
module sync_event_arbiter
  import sync_event_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         ev_in,
  input  logic [NREQ-1:0]         ev_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic [CNT_W-1:0]        out_cnt,
  output logic [NREQ-1:0]         ovf,
  input  logic [NREQ-1:0]         ovf_clr,
  output state_t                  fsm_state
);

  localparam int IDW = $clog2(NREQ);

  if (!params_legal(NREQ, CNT_W)) begin : g_bad_params
    $error("sync_event_arbiter: NREQ or CNT_W out of range");
  end

  // Handshake: a record transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low the
  // record (out_id, out_cnt) is frozen and cannot be withdrawn.

  state_t           state;
  logic [NREQ-1:0]  ev_q;
  logic [CNT_W-1:0] pend_cnt [NREQ];
  logic [IDW-1:0]   last_id;

  logic [NREQ-1:0]  rise_en;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  ovf_set;
  logic [NREQ-1:0]  granted;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_id;
  logic             take;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_rr (
    .req       (eligible),
    .last_id   (last_id),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // A grant happens whenever the output slot is free or is being freed this edge.
  assign take = gnt_valid && ((state == IDLE) || out_ready);

  // An edge coinciding with the grant of its own channel restarts the count
  // instead of overflowing it, so it never raises ovf.
  always_comb begin
    rise_en  = ev_in & ~ev_q & ~ev_mask;
    eligible = '0;
    granted  = '0;
    ovf_set  = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = (pend_cnt[i] != '0) && !ev_mask[i];
      granted[i]  = take && (gnt_id == IDW'(i));
      ovf_set[i]  = rise_en[i] && (&pend_cnt[i]) && !granted[i];
    end
  end

  always_ff @(posedge clk) begin
    ev_q <= ev_in;
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_cnt   <= '0;
      ovf       <= '0;
      last_id   <= IDW'(NREQ - 1);
      for (int i = 0; i < NREQ; i++) begin
        pend_cnt[i] <= '0;
      end
    end else begin
      ovf <= (ovf & ~ovf_clr) | ovf_set;

      for (int i = 0; i < NREQ; i++) begin
        if (granted[i]) begin
          pend_cnt[i] <= CNT_W'(rise_en[i]);
        end else if (rise_en[i] && !(&pend_cnt[i])) begin
          pend_cnt[i] <= pend_cnt[i] + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state     <= PRESENT;
            out_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready && !gnt_valid) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase

      if (take) begin
        out_id  <= gnt_id;
        out_cnt <= pend_cnt[gnt_id];
        last_id <= gnt_id;
      end
    end
  end

  assign fsm_state = state;

endmodule
